// File: rtl/odo_round_key_sequencer.sv
// Odo round-key sequencer: fetches ten keys from the round-key ROM, buffers them, then streams them over valid/ready.
// Optional feature macro ODO_RK_CACHE_EN: once a fetch has completed, later starts replay the buffer without refetching.
module odo_round_key_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] rk_period,
    input  logic [9:0] rk_key,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [9:0] key_data,
    output logic [3:0] key_index,
    output logic       key_last,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_FLUSH,
        S_STREAM
    } state_t;

    state_t     r_state;
    logic [3:0] r_period;
    logic       r_valid;
    logic [9:0] r_data;
    logic [3:0] r_index;
    logic       r_last;
    logic       r_busy;
    logic       r_done;

    logic [9:0] r_buf [0:9];

    logic       w_transfer;
    logic       w_cap_en;
    logic [3:0] w_cap_addr;
    logic [3:0] w_next_index;
    logic       w_cache_hit;

    assign w_transfer   = r_valid && key_ready;
    assign w_next_index = r_index + 4'd1;

    // The ROM answers one cycle late, so the key arriving now belongs to the previously issued period.
    assign w_cap_en   = ((r_state == S_FETCH) && (r_period != 4'd0)) || (r_state == S_FLUSH);
    assign w_cap_addr = (r_state == S_FLUSH) ? 4'd9 : (r_period - 4'd1);

`ifdef ODO_RK_CACHE_EN
    logic r_cached;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cached <= 1'b0;
        end else if (r_state == S_FLUSH) begin
            r_cached <= 1'b1;
        end
    end

    assign w_cache_hit = r_cached;
`else
    assign w_cache_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (w_cap_en) begin
            r_buf[w_cap_addr] <= rk_key;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_period <= 4'd0;
            r_valid  <= 1'b0;
            r_data   <= 10'd0;
            r_index  <= 4'd0;
            r_last   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_busy <= 1'b1;
                        if (w_cache_hit) begin
                            r_state <= S_STREAM;
                            r_valid <= 1'b1;
                            r_data  <= r_buf[0];
                            r_index <= 4'd0;
                            r_last  <= 1'b0;
                        end else begin
                            r_state  <= S_FETCH;
                            r_period <= 4'd0;
                        end
                    end
                end
                S_FETCH: begin
                    if (r_period == 4'd9) begin
                        r_state  <= S_FLUSH;
                        r_period <= 4'd0;
                    end else begin
                        r_period <= r_period + 4'd1;
                    end
                end
                S_FLUSH: begin
                    r_state <= S_STREAM;
                    r_valid <= 1'b1;
                    r_data  <= r_buf[0];
                    r_index <= 4'd0;
                    r_last  <= 1'b0;
                end
                S_STREAM: begin
                    if (w_transfer) begin
                        if (r_last) begin
                            r_state <= S_IDLE;
                            r_valid <= 1'b0;
                            r_index <= 4'd0;
                            r_last  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_data  <= r_buf[w_next_index];
                            r_index <= w_next_index;
                            r_last  <= (r_index == 4'd8);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rk_period = r_period;
    assign key_valid = r_valid;
    assign key_data  = r_data;
    assign key_index = r_index;
    assign key_last  = r_last;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_odo_round_key_sequencer.sv
// Self-checking bench for odo_round_key_sequencer: timeline/handshake model plus a ROM model.
// Expectations adapt to ODO_RK_CACHE_EN when the bench is built with the same define as the design.
module tb_odo_round_key_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       key_ready = 1'b0;
    logic [9:0] rk_key;
    logic [3:0] rk_period;
    logic       key_valid;
    logic [9:0] key_data;
    logic [3:0] key_index;
    logic       key_last;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;
    bit bench_cached = 1'b0;

    logic [9:0] rom        [0:9];
    logic [9:0] cache_keys [0:9];

    odo_round_key_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .rk_period (rk_period),
        .rk_key    (rk_key),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_data  (key_data),
        .key_index (key_index),
        .key_last  (key_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // ROM model with one registered cycle of latency
    always @(posedge clk) begin
        rk_key <= (rk_period <= 4'd9) ? rom[rk_period] : 10'h3ff;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rk_period"}, rk_period, 0);
        chk({tag, "_key_valid"}, key_valid, 0);
        chk({tag, "_key_data"},  key_data,  0);
        chk({tag, "_key_index"}, key_index, 0);
        chk({tag, "_key_last"},  key_last,  0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
    endtask

    // Issue one start and follow the whole sequence cycle by cycle. Returns the cycle in which done was seen.
    task automatic run_seq(input int sidx, input int slen, input bit inject, input bit rnd, output int dut_done);
        int  acc, stall_cnt, done_cyc, f, c;
        bit  cached, rdy, exp_valid, exp_busy, exp_done;
        logic [9:0] exp_key;
        cached    = bench_cached;
        f         = cached ? 0 : 11;
        acc       = 0;
        stall_cnt = 0;
        done_cyc  = -1;
        dut_done  = -1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (c = 1; c < 200; c++) begin
            exp_valid = (c > f) && (acc < 10);
            exp_busy  = (acc < 10);
            exp_done  = (c == done_cyc);
            chk("rk_period", rk_period, (!cached && c <= 10) ? c - 1 : 0);
            chk("busy", busy, exp_busy);
            chk("key_valid", key_valid, exp_valid);
            chk("done", done, exp_done);
            if (done === 1'b1 && dut_done < 0) dut_done = c;
            if (exp_valid) begin
                exp_key = cached ? cache_keys[acc] : rom[acc];
                chk("key_index", key_index, acc);
                chk("key_data", key_data, exp_key);
                chk("key_last", key_last, acc == 9);
            end
            if (exp_done) break;
            rdy = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!rnd && exp_valid && acc == sidx && stall_cnt < slen) begin
                rdy = 1'b0;
                stall_cnt++;
            end
            key_ready = rdy;
            start = inject && (c == 5 || c == f + 3);
            tick();
            start = 1'b0;
            if (exp_valid && rdy) begin
                acc++;
                if (acc == 10) done_cyc = c + 1;
            end
        end
        if (c >= 200) chk("seq_timeout", c, 0);
        if (!cached) begin
            foreach (rom[i]) cache_keys[i] = rom[i];
        end
`ifdef ODO_RK_CACHE_EN
        bench_cached = 1'b1;
`endif
        $display("seq cached=%0d stall_idx=%0d stall_len=%0d inject=%0d rnd=%0d done_cycle=%0d", cached, sidx, slen, inject, rnd, dut_done);
    endtask

    typedef struct {
        int sidx;
        int slen;
        bit inject;
        bit rnd;
        bit new_rom;
        int exp_done_full;
        int exp_done_cached;
    } vec_t;

    vec_t vecs [0:5];

    initial begin
        int dd;
        bit cached_now;

        vecs[0] = '{0, 0, 1'b0, 1'b0, 1'b0, 22, 11};
        vecs[1] = '{4, 3, 1'b0, 1'b0, 1'b0, 25, 14};
        vecs[2] = '{0, 0, 1'b1, 1'b0, 1'b0, 22, 11};
        vecs[3] = '{0, 0, 1'b0, 1'b1, 1'b1, -1, -1};
        vecs[4] = '{9, 2, 1'b0, 1'b0, 1'b1, 24, 13};
        vecs[5] = '{0, 0, 1'b0, 1'b1, 1'b0, -1, -1};

        rom[0] = 10'h10e; rom[1] = 10'h0c1; rom[2] = 10'h120; rom[3] = 10'h21d; rom[4] = 10'h311;
        rom[5] = 10'h240; rom[6] = 10'h366; rom[7] = 10'h3c6; rom[8] = 10'h2e2; rom[9] = 10'h144;

        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            if (vecs[v].new_rom) begin
                foreach (rom[i]) rom[i] = 10'($urandom_range(0, 1023));
            end
            cached_now = bench_cached;
            run_seq(vecs[v].sidx, vecs[v].slen, vecs[v].inject, vecs[v].rnd, dd);
            if (vecs[v].exp_done_full >= 0) begin
                chk("done_cycle", dd, cached_now ? vecs[v].exp_done_cached : vecs[v].exp_done_full);
            end
        end

        // Reset asserted in the sixth cycle of a sequence, away from any clock edge
        cached_now = bench_cached;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("pre_reset_busy", busy, 1);
        chk("pre_reset_rk_period", rk_period, cached_now ? 0 : 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        chk_reset_outputs("held_reset");
        rst_n = 1'b1;
        bench_cached = 1'b0;
        tick();
        chk("post_reset_done", done, 0);

        run_seq(0, 0, 1'b0, 1'b0, dd);
        chk("done_cycle_after_reset", dd, 22);

        // Second start after a completed fetch: cached replay or full refetch depending on the build
        cached_now = bench_cached;
        run_seq(0, 0, 1'b0, 1'b0, dd);
        chk("done_cycle_second", dd, cached_now ? 11 : 22);

        tick();
        chk("final_idle_busy", busy, 0);
        chk("final_idle_done", done, 0);
        chk("final_idle_valid", key_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/odo_round_key_sequencer.md
# odo_round_key_sequencer

Consumer side of the Odo round-key ROM: on a start request it walks the ROM's `period` input through 0..9, captures each 10-bit key (the ROM has one registered cycle of latency), and buffers all ten. It then streams the keys in period order to the round datapath over a valid/ready handshake. It sits between the round-key ROM and the Odo round engine in the miner core.

## Interface
Parameters: none; the key count (10) and key width (10) are fixed by the ROM.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a sequence; honoured only in IDLE.
- `rk_period`  out  4  period index driven to the ROM.
- `rk_key`  in  10  ROM key output, valid the cycle after `rk_period` is presented.
- `key_valid`  out  1  `key_data` holds an offered key.
- `key_ready`  in  1  consumer accepts; a transfer is `key_valid && key_ready` at a rising edge.
- `key_data`  out  10  offered key.
- `key_index`  out  4  period of the offered key, 0..9.
- `key_last`  out  1  high with `key_index==9`.
- `busy`  out  1  high whenever state is not IDLE.
- `done`  out  1  one-cycle pulse after the index-9 key transfers.

## Operation
- States: IDLE, FETCH, FLUSH, STREAM.
- IDLE, `start=1` -> FETCH with issue counter p=0. If `ODO_RK_CACHE_EN` is defined and the cache flag is set, go directly to STREAM instead.
- FETCH: drive `rk_period=p`. Each cycle capture `rk_key` into buf[p-1] when p>0, then increment p. After p=9 is issued -> FLUSH.
- FLUSH: capture `rk_key` into buf[9] -> STREAM, loading `key_data=buf[0]`, `key_index=0` and `key_valid=1`. Set the cache flag.
- STREAM: on each transfer with index<9, load the next entry. Transfer at index 9 -> IDLE, `key_valid=0`, `done=1` for one cycle.
- While `key_valid && !key_ready`, `key_data`, `key_index` and `key_last` hold stable.
- `start` outside IDLE is ignored and not queued. `start` in the same cycle `done` is high is honoured, because the state is already IDLE.
- `rk_period` is 0 outside FETCH and never exceeds 9. Periods 10..15 are never issued.
- All outputs are registered.

## Timing
- Reset (async assert, sync release): state IDLE; `rk_period=0`, `key_valid=0`, `key_data=0`, `key_index=0`, `key_last=0`, `busy=0`, `done=0`; cache flag cleared. Buffer contents are don't-care.
- Reset mid-FETCH or mid-STREAM aborts immediately and no `done` is produced.
- With `start` sampled at edge T (full fetch):
  - `rk_period` = 0..9 in cycles T+1..T+10.
  - `rk_key` is captured at the ends of T+2..T+11.
  - `key_valid` rises in T+12.
  - With `key_ready` tied high, keys 0..9 occupy T+12..T+21 and `done` pulses in T+22.
  - `busy` is high T+1..T+21.
- Cached start at T: `key_valid` rises in T+1; with ready high, `done` pulses in T+11.
- Each stalled cycle (ready low) delays `done` by one cycle.

## Configuration
- `ODO_RK_CACHE_EN` defined:
  - After the first completed fetch, later starts skip FETCH/FLUSH and stream the buffer directly.
  - The cache flag is cleared only by reset.
- Not defined:
  - Every start refetches all ten keys.
  - No cache flag is implemented.

## Test plan
- Reset, then `start` with ready high and the ROM modelled (0x10e, 0x0c1, 0x120, 0x21d, 0x311, 0x240, 0x366, 0x3c6, 0x2e2, 0x144) -> `rk_period` 0..9 in T+1..T+10; those ten keys with index 0..9 in T+12..T+21; `key_last` high only at 0x144; `done` in T+22.
- Same, with `key_ready` low for 3 cycles at index 4 -> `key_data` holds 0x311 with index 4 stable; `done` moves to T+25; no key dropped or duplicated.
- `start` pulses in FETCH and STREAM -> ignored; exactly one sequence is streamed and one `done`.
- `rst_n` low at T+6 mid-FETCH -> all outputs return to reset values asynchronously; a new `start` afterwards produces the full T+1..T+22 timeline.
- `ODO_RK_CACHE_EN` defined: second `start` -> `rk_period` stays 0; `key_valid` in T+1 with key 0x10e; `done` in T+11.
- `ODO_RK_CACHE_EN` undefined: second `start` -> full refetch timeline, with `done` in T+22.
